dds_wave_gen: RTL and testbench

Parametrised DDS waveform generator: a phase accumulator with a programmable tuning word drives sine (external ROM), square (programmable duty), triangle and sawtooth generation. The block then applies amplitude gain and offset with saturation. Configuration is loaded through a valid/ready handshake and is applied only at a period boundary, so frequency and waveform changes are glitch-free. It sits between the front-panel control logic and the DAC data path.

---
 rtl/dds_wave_gen.sv | 206 ++++++++++++++++++++
 tb/tb_dds_wave_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator feeding sine/square/triangle/saw shaping,
// then gain and saturating offset. Config updates land only on a period boundary.
module dds_wave_gen #(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned LUT_AW = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_wave,
    input  logic [ACC_W-1:0]  cfg_ftw,
    input  logic [ACC_W-1:0]  cfg_pow,
    input  logic [DATA_W-1:0] cfg_duty,
    input  logic [DATA_W-1:0] cfg_gain,
    input  logic [DATA_W-1:0] cfg_offset,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              sync
);

    localparam int unsigned PW = 2 * DATA_W;

    typedef struct packed {
        logic [1:0]        wave;
        logic [ACC_W-1:0]  ftw;
        logic [ACC_W-1:0]  pow;
        logic [DATA_W-1:0] duty;
        logic [DATA_W-1:0] gain;
        logic [DATA_W-1:0] offset;
    } cfg_t;

    // Per-sample snapshot of the shaping config, so an update never splits a sample.
    typedef struct packed {
        logic [1:0]        wave;
        logic [DATA_W-1:0] duty;
        logic [DATA_W-1:0] gain;
        logic [DATA_W-1:0] offset;
    } smp_cfg_t;

    localparam cfg_t CFG_RST = '{
        wave:   2'd0,
        ftw:    '0,
        pow:    '0,
        duty:   {1'b1, {(DATA_W-1){1'b0}}},
        gain:   '1,
        offset: '0
    };

    cfg_t              act_q, act_d, sh_q, sh_d;
    logic              pending_q, pending_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              wrap_q, wrap_d;
    logic [ACC_W-1:0]  ph1_q, ph1_d;
    logic              v1_q, v1_d, s1_q, s1_d;
    smp_cfg_t          c1_q, c1_d;
    logic [DATA_W-1:0] ph2_q, ph2_d;
    logic              v2_q, v2_d, s2_q, s2_d;
    smp_cfg_t          c2_q, c2_d;
    logic [DATA_W-1:0] raw_q, raw_d, gain3_q, gain3_d, off3_q, off3_d;
    logic              v3_q, v3_d, s3_q, s3_d;
    logic [DATA_W-1:0] scaled_q, scaled_d, off4_q, off4_d;
    logic              v4_q, v4_d, s4_q, s4_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d, sync_q, sync_d;

    logic [ACC_W:0]    acc_sum;
    logic              capture, apply;
    logic [DATA_W-1:0] tri_v;
    logic [PW-1:0]     prod;
    logic [DATA_W:0]   out_sum;

    // Config handshake, accumulator and sample pipeline.
    always_comb begin
        act_d     = act_q;
        sh_d      = sh_q;
        pending_d = pending_q;
        acc_d     = acc_q;
        wrap_d    = 1'b0;
        ph1_d     = ph1_q;
        c1_d      = c1_q;

        acc_sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(act_q.ftw);
        capture = cfg_valid && !pending_q;
        apply   = pending_q && (!en || (act_q.ftw == '0) || acc_sum[ACC_W]);

        if (en) begin
            acc_d  = acc_sum[ACC_W-1:0];
            wrap_d = acc_sum[ACC_W];
            ph1_d  = acc_q + act_q.pow;
            c1_d   = '{wave: act_q.wave, duty: act_q.duty,
                       gain: act_q.gain, offset: act_q.offset};
        end
        v1_d = en;
        s1_d = en && (!v1_q || wrap_q);

        if (apply) begin
            act_d     = sh_q;
            pending_d = 1'b0;
        end else if (capture) begin
            sh_d      = '{wave: cfg_wave, ftw: cfg_ftw, pow: cfg_pow,
                          duty: cfg_duty, gain: cfg_gain, offset: cfg_offset};
            pending_d = 1'b1;
        end
        cfg_ready_d = !pending_d;

        ph2_d = DATA_W'(ph1_q >> (ACC_W - DATA_W));
        v2_d  = v1_q;
        s2_d  = s1_q;
        c2_d  = c1_q;

        // Triangle folds the upper half of the ramp back down.
        tri_v = {ph2_q[DATA_W-2:0], 1'b0};
        case (c2_q.wave)
            2'd0:    raw_d = lut_data;
            2'd1:    raw_d = (ph2_q < c2_q.duty) ? '1 : '0;
            2'd2:    raw_d = ph2_q[DATA_W-1] ? ~tri_v : tri_v;
            default: raw_d = ph2_q;
        endcase
        v3_d    = v2_q;
        s3_d    = s2_q;
        gain3_d = c2_q.gain;
        off3_d  = c2_q.offset;

        prod     = PW'(raw_q) * PW'(gain3_q) + PW'(raw_q);
        scaled_d = DATA_W'(prod >> DATA_W);
        v4_d     = v3_q;
        s4_d     = s3_q;
        off4_d   = off3_q;

        out_sum      = (DATA_W+1)'(scaled_q) + (DATA_W+1)'(off4_q);
        dout_d       = !v4_q ? '0 : (out_sum[DATA_W] ? '1 : out_sum[DATA_W-1:0]);
        dout_valid_d = v4_q;
        sync_d       = v4_q && s4_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_q        <= CFG_RST;
            sh_q         <= CFG_RST;
            pending_q    <= 1'b0;
            cfg_ready_q  <= 1'b1;
            acc_q        <= '0;
            wrap_q       <= 1'b0;
            ph1_q        <= '0;
            v1_q         <= 1'b0;
            s1_q         <= 1'b0;
            c1_q         <= '0;
            ph2_q        <= '0;
            v2_q         <= 1'b0;
            s2_q         <= 1'b0;
            c2_q         <= '0;
            raw_q        <= '0;
            v3_q         <= 1'b0;
            s3_q         <= 1'b0;
            gain3_q      <= '0;
            off3_q       <= '0;
            scaled_q     <= '0;
            v4_q         <= 1'b0;
            s4_q         <= 1'b0;
            off4_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_q       <= 1'b0;
        end else begin
            act_q        <= act_d;
            sh_q         <= sh_d;
            pending_q    <= pending_d;
            cfg_ready_q  <= cfg_ready_d;
            acc_q        <= acc_d;
            wrap_q       <= wrap_d;
            ph1_q        <= ph1_d;
            v1_q         <= v1_d;
            s1_q         <= s1_d;
            c1_q         <= c1_d;
            ph2_q        <= ph2_d;
            v2_q         <= v2_d;
            s2_q         <= s2_d;
            c2_q         <= c2_d;
            raw_q        <= raw_d;
            v3_q         <= v3_d;
            s3_q         <= s3_d;
            gain3_q      <= gain3_d;
            off3_q       <= off3_d;
            scaled_q     <= scaled_d;
            v4_q         <= v4_d;
            s4_q         <= s4_d;
            off4_q       <= off4_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_q       <= sync_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign lut_addr   = LUT_AW'(ph1_q >> (ACC_W - LUT_AW));
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sync       = sync_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Randomised self-checking bench for dds_wave_gen against a sample-level reference model.
module tb_dds_wave_gen;

    localparam int unsigned ACC_W  = 16;
    localparam int unsigned LUT_AW = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned MAXV   = (1 << DATA_W) - 1;
    localparam int unsigned MODV   = 1 << ACC_W;

    logic              clk = 1'b0;
    logic              rst_n, en, cfg_valid, cfg_ready;
    logic [1:0]        cfg_wave;
    logic [ACC_W-1:0]  cfg_ftw, cfg_pow;
    logic [DATA_W-1:0] cfg_duty, cfg_gain, cfg_offset;
    logic [LUT_AW-1:0] lut_addr;
    logic [DATA_W-1:0] lut_data;
    logic [DATA_W-1:0] dout;
    logic              dout_valid, sync;

    dds_wave_gen #(.ACC_W(ACC_W), .LUT_AW(LUT_AW), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_wave(cfg_wave), .cfg_ftw(cfg_ftw), .cfg_pow(cfg_pow),
        .cfg_duty(cfg_duty), .cfg_gain(cfg_gain), .cfg_offset(cfg_offset),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .dout(dout), .dout_valid(dout_valid), .sync(sync)
    );

    always #5 clk = ~clk;

    // External sine ROM with one cycle of read latency.
    logic [DATA_W-1:0] rom [1 << LUT_AW];
    always @(posedge clk) lut_data <= rom[lut_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: active and shadow config, phase, expected sample queue.
    int unsigned m_wave, m_ftw, m_pow, m_duty, m_gain, m_offset;
    int unsigned s_wave, s_ftw, s_pow, s_duty, s_gain, s_offset;
    int unsigned m_acc, m_lut, cyc;
    bit          m_pending, m_prev_en, m_wrapped, m_captured;
    int unsigned q_due[$], q_val[$];
    bit          q_sync[$];

    function automatic int unsigned sample_of(input int unsigned ph);
        int unsigned p, raw, sc;
        p = ph >> (ACC_W - DATA_W);
        case (m_wave)
            0:       raw = rom[LUT_AW'(ph >> (ACC_W - LUT_AW))];
            1:       raw = (p < m_duty) ? MAXV : 0;
            2:       raw = (p < (MAXV + 1) / 2) ? 2 * p : MAXV - 2 * (p - (MAXV + 1) / 2);
            default: raw = p;
        endcase
        sc = (raw * (m_gain + 1)) >> DATA_W;
        return (sc + m_offset > MAXV) ? MAXV : sc + m_offset;
    endfunction

    task automatic model_reset();
        m_wave = 0; m_ftw = 0; m_pow = 0; m_duty = (MAXV + 1) / 2; m_gain = MAXV; m_offset = 0;
        m_acc = 0; m_lut = 0; m_pending = 0; m_prev_en = 0; m_wrapped = 0;
        q_due.delete(); q_val.delete(); q_sync.delete();
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_edge();
        int unsigned nxt, ph;
        bit carry, do_apply;
        m_captured = 0;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        nxt      = m_acc + m_ftw;
        carry    = nxt >= MODV;
        do_apply = m_pending && (!en || m_ftw == 0 || carry);
        if (en) begin
            ph = (m_acc + m_pow) % MODV;
            q_due.push_back(cyc + 4);
            q_val.push_back(sample_of(ph));
            q_sync.push_back(!m_prev_en || m_wrapped);
            m_lut     = ph >> (ACC_W - LUT_AW);
            m_wrapped = carry;
            m_acc     = nxt % MODV;
        end
        m_prev_en = en;
        if (do_apply) begin
            m_wave = s_wave; m_ftw = s_ftw; m_pow = s_pow;
            m_duty = s_duty; m_gain = s_gain; m_offset = s_offset;
            m_pending = 0;
        end else if (cfg_valid && !m_pending) begin
            s_wave = cfg_wave; s_ftw = cfg_ftw; s_pow = cfg_pow;
            s_duty = cfg_duty; s_gain = cfg_gain; s_offset = cfg_offset;
            m_pending  = 1;
            m_captured = 1;
        end
    endtask

    task automatic tick();
        int unsigned e_val;
        bit e_vld, e_sync;
        model_edge();
        @(posedge clk);
        #1;
        e_vld = 0; e_val = 0; e_sync = 0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            void'(q_due.pop_front());
            e_vld  = 1;
            e_val  = q_val.pop_front();
            e_sync = q_sync.pop_front();
        end
        check("dout_valid", dout_valid, e_vld);
        check("dout", dout, e_val);
        check("sync", sync, e_sync);
        check("cfg_ready", cfg_ready, !m_pending);
        check("lut_addr", lut_addr, m_lut);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_cfg(input int unsigned w, ftw, pow, duty, gain, off);
        cfg_wave = 2'(w); cfg_ftw = ACC_W'(ftw); cfg_pow = ACC_W'(pow);
        cfg_duty = DATA_W'(duty); cfg_gain = DATA_W'(gain); cfg_offset = DATA_W'(off);
    endtask

    // Hold an offer until the model sees it taken; a stuck handshake is reported.
    task automatic offer(input int unsigned w, ftw, pow, duty, gain, off);
        drive_cfg(w, ftw, pow, duty, gain, off);
        cfg_valid = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (m_captured) break;
        end
        if (!m_captured) check("offer_timeout", cfg_ready, 1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << LUT_AW); i++)
            rom[i] = DATA_W'($rtoi(127.5 + 127.0 * $sin(6.283185307 * i / 256.0)));
        cyc = 0;
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        drive_cfg(0, 0, 0, 0, 0, 0);
        model_reset();
        run(3);
        rst_n = 1'b1;

        // Saw ramp, then square with two duties.
        offer(3, 'h0100, 0, 128, 255, 0);
        tick();
        en = 1'b1;
        run(300);
        offer(1, 'h0100, 0, 64, 255, 0);
        run(300);
        offer(1, 'h0100, 0, 0, 255, 0);
        run(300);

        // Triangle, then saw with gain and saturating offset.
        offer(2, 'h0100, 0, 128, 255, 0);
        run(300);
        offer(3, 'h0100, 0, 128, 127, 200);
        run(300);

        // Sine through the ROM, with and without phase offset.
        offer(0, 'h0100, 0, 128, 255, 0);
        run(300);
        offer(0, 'h0300, 'h4000, 128, 255, 0);
        run(200);

        // Mid-period frequency change, then updates while stopped and at ftw=0.
        offer(3, 'h0100, 0, 128, 255, 0);
        run(400);
        offer(3, 'h0200, 0, 128, 255, 0);
        run(400);
        en = 1'b0;
        run(3);
        offer(3, 'h0300, 0, 128, 255, 0);
        run(3);
        en = 1'b1;
        run(100);
        offer(3, 0, 'h1234, 128, 255, 0);
        run(50);
        offer(2, 'h0100, 0, 128, 255, 0);
        run(20);

        // Reset with an update pending, then a saw parked at ftw=0.
        offer(3, 'h0100, 0, 128, 255, 0);
        run(300);
        offer(1, 'h0080, 0, 100, 255, 0);
        run(5);
        rst_n = 1'b0;
        tick();
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_ready", cfg_ready, 1);
        rst_n = 1'b1;
        offer(3, 0, 0, 128, 255, 0);
        run(50);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 15) != 0);
            if (cfg_valid && m_captured) cfg_valid = 1'b0;
            if (!cfg_valid && $urandom_range(0, 99) < 3) begin
                drive_cfg($urandom_range(0, 3),
                          ($urandom_range(0, 7) == 0) ? 0 : $urandom_range('h40, 'h1000),
                          $urandom_range(0, MODV - 1), $urandom_range(0, MAXV),
                          $urandom_range(0, MAXV), $urandom_range(0, MAXV));
                cfg_valid = 1'b1;
            end
            rst_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst_n = 1'b1;
        cfg_valid = 1'b0;
        en = 1'b0;
        run(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
